// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: row-major operand issue, tag delay line matched to the
// inner-product pipeline, and a credit-protected result FIFO with valid/ready output.
module gemm_tile_sequencer #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PIPE_LAT   = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W-1:0]      cfg_m,
  input  logic [IDX_W-1:0]      cfg_n,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [IDX_W-1:0]      rd_row,
  output logic [IDX_W-1:0]      rd_col,
  input  logic [DATA_WIDTH-1:0] ipu_data_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDX_W-1:0]      res_row,
  output logic [IDX_W-1:0]      res_col
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } tag_t;

  typedef struct packed {
    logic [IDX_W-1:0]      row;
    logic [IDX_W-1:0]      col;
    logic [DATA_WIDTH-1:0] data;
  } res_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] m_q, n_q;
  logic [IDX_W-1:0] row_nxt, col_nxt;
  logic             rd_en_nxt, busy_nxt, done_nxt;
  logic             last_col, last_issue, credit_nxt;

  logic [CNT_W-1:0] inflight, inflight_nxt;
  logic [CNT_W-1:0] fifo_count, fifo_count_nxt;
  logic             fifo_wr, fifo_rd;

  logic [PIPE_LAT-1:0] dl_vld;
  tag_t                dl_tag [PIPE_LAT];

  res_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  res_t             wr_entry, head_nxt, res_q;

  assign fifo_wr = dl_vld[PIPE_LAT-1];
  assign fifo_rd = res_valid & res_ready;

  assign last_col   = (rd_col == n_q - IDX_W'(1));
  assign last_issue = rd_en & last_col & (rd_row == m_q - IDX_W'(1));

  // Outstanding work (in pipeline plus buffered) must stay within FIFO capacity.
  assign inflight_nxt   = inflight + CNT_W'(rd_en) - CNT_W'(fifo_wr);
  assign fifo_count_nxt = fifo_count + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
  assign credit_nxt     = (SUM_W'(inflight_nxt) + SUM_W'(fifo_count_nxt)) < SUM_W'(FIFO_DEPTH);

  // Next state, next issue index and next registered control outputs.
  always_comb begin
    state_nxt = state;
    row_nxt   = rd_row;
    col_nxt   = rd_col;
    rd_en_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          row_nxt   = '0;
          col_nxt   = '0;
          state_nxt = (cfg_m == '0 || cfg_n == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (fifo_rd && inflight == '0 && fifo_count == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Column is the inner loop; the index holds on the final issue.
    if (state == RUN && rd_en && !last_issue) begin
      if (last_col) begin
        col_nxt = '0;
        row_nxt = rd_row + IDX_W'(1);
      end else begin
        col_nxt = rd_col + IDX_W'(1);
      end
    end

    rd_en_nxt = (state_nxt == RUN) && !last_issue && credit_nxt;
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_en  <= 1'b0;
      rd_row <= '0;
      rd_col <= '0;
      m_q    <= '0;
      n_q    <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      rd_en  <= rd_en_nxt;
      rd_row <= row_nxt;
      rd_col <= col_nxt;
      if (state == IDLE && start) begin
        m_q <= cfg_m;
        n_q <= cfg_n;
      end
    end
  end

  // Tag delay line aligned with the inner-product pipeline latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_vld <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) dl_tag[k] <= '0;
    end else begin
      dl_vld[0]     <= rd_en;
      dl_tag[0].row <= rd_row;
      dl_tag[0].col <= rd_col;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        dl_vld[k] <= dl_vld[k-1];
        dl_tag[k] <= dl_tag[k-1];
      end
    end
  end

  // Head of queue for the next cycle; bypass covers a write into an emptying FIFO.
  always_comb begin
    wr_entry.row  = dl_tag[PIPE_LAT-1].row;
    wr_entry.col  = dl_tag[PIPE_LAT-1].col;
    wr_entry.data = ipu_data_in;
    rd_ptr_nxt    = rd_ptr + PTR_W'(fifo_rd);
    head_nxt      = (fifo_wr && (wr_ptr == rd_ptr_nxt)) ? wr_entry : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      res_valid  <= 1'b0;
      res_q      <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(fifo_wr);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= fifo_count_nxt;
      inflight   <= inflight_nxt;
      res_valid  <= (fifo_count_nxt != '0);
      if (fifo_count_nxt != '0) res_q <= head_nxt;
    end
  end

  assign res_data = res_q.data;
  assign res_row  = res_q.row;
  assign res_col  = res_q.col;

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_wr && !fifo_rd && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer with a fixed-latency inner-product model.
module tb_gemm_tile_sequencer;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 5;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             res_ready = 1'b0;
  logic [IDX_W-1:0] cfg_m = '0;
  logic [IDX_W-1:0] cfg_n = '0;
  logic [DW-1:0]    ipu_data_in = '0;
  logic             busy, done, rd_en, res_valid;
  logic [IDX_W-1:0] rd_row, rd_col, res_row, res_col;
  logic [DW-1:0]    res_data;

  always #5 clk = ~clk;

  gemm_tile_sequencer #(
    .IDX_W(IDX_W), .DATA_WIDTH(DW), .PIPE_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
    .ipu_data_in(ipu_data_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cycle    = 0;
  logic [7:0] tile_tag = 8'h00;

  // Inner-product model: result for an issue appears LAT cycles later.
  logic          hv [LAT+1];
  logic [DW-1:0] hd [LAT+1];

  initial begin
    for (int k = 0; k <= int'(LAT); k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
  end

  always @(negedge clk) begin
    for (int k = int'(LAT); k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = rd_en;
    hd[0] = {tile_tag, 8'h3C, rd_row, rd_col};
    ipu_data_in = hv[LAT] ? hd[LAT] : 32'hDEAD_BEEF;
  end

  // Tile tracking
  int exp_m, exp_n, ir, ic, rr, rc;
  int n_issued, n_res, n_done, t_start, first_valid, last_hs, done_cycle, max_out;
  logic consec, hold_pending, prev_done;
  logic [DW-1:0] held_data;
  logic [15:0]   held_tag;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"},      32'(busy),      0);
    chk({pfx, "_done"},      32'(done),      0);
    chk({pfx, "_rd_en"},     32'(rd_en),     0);
    chk({pfx, "_res_valid"}, 32'(res_valid), 0);
    chk({pfx, "_rd_row"},    32'(rd_row),    0);
    chk({pfx, "_rd_col"},    32'(rd_col),    0);
    chk({pfx, "_res_data"},  res_data,       0);
    chk({pfx, "_res_row"},   32'(res_row),   0);
    chk({pfx, "_res_col"},   32'(res_col),   0);
  endtask

  // One clock: drive inputs mid-cycle, then check this cycle's outputs.
  task automatic cyc(input logic st, input logic rdy);
    logic hs;
    @(negedge clk);
    cycle++;
    start     = st;
    res_ready = rdy;
    if (prev_done) begin
      chk("busy_after_done", 32'(busy), 0);
      prev_done = 1'b0;
    end
    if (rd_en) begin
      chk("issue_row", 32'(rd_row), 32'(ir));
      chk("issue_col", 32'(rd_col), 32'(ic));
      if (consec) chk("issue_cycle", 32'(cycle), 32'(t_start + 1 + n_issued));
      n_issued++;
      chk("issue_bound", 32'(n_issued <= exp_m * exp_n), 1);
      if (ic == exp_n - 1) begin ic = 0; ir++; end else ic++;
    end
    if (hold_pending) begin
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", res_data, held_data);
      chk("hold_tag", 32'({res_row, res_col}), 32'(held_tag));
    end
    if (res_valid && first_valid < 0) first_valid = cycle;
    hs = res_valid && rdy;
    if (hs) begin
      chk("res_row", 32'(res_row), 32'(rr));
      chk("res_col", 32'(res_col), 32'(rc));
      chk("res_data", res_data, {tile_tag, 8'h3C, 8'(rr), 8'(rc)});
      n_res++;
      last_hs = cycle;
      if (rc == exp_n - 1) begin rc = 0; rr++; end else rc++;
    end
    hold_pending = res_valid && !rdy;
    held_data    = res_data;
    held_tag     = {res_row, res_col};
    if (done) begin
      n_done++;
      done_cycle = cycle;
      prev_done  = 1'b1;
    end
    if (n_issued - n_res > max_out) max_out = n_issued - n_res;
  endtask

  task automatic begin_tile(input int m, input int n, input logic [7:0] tag,
                            input logic cons, input logic rdy);
    cfg_m = 8'(m); cfg_n = 8'(n); tile_tag = tag;
    exp_m = m; exp_n = n; ir = 0; ic = 0; rr = 0; rc = 0;
    n_issued = 0; n_res = 0; n_done = 0; first_valid = -1; last_hs = -1;
    done_cycle = -1; max_out = 0; consec = cons; hold_pending = 1'b0;
    cyc(1'b1, rdy);
    t_start = cycle;
  endtask

  task automatic run_to_done(input int mode, input int budget);
    int d0 = n_done;
    int k = 0;
    logic r;
    while (n_done == d0 && k < budget) begin
      r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b0, r);
      k++;
    end
    chk("done_within_budget", 32'(n_done != d0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    prev_done = 1'b0; hold_pending = 1'b0; consec = 1'b0;
    exp_m = 0; exp_n = 0; n_issued = 0; n_res = 0; n_done = 0; max_out = 0;

    // Reset values
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // Basic 2x3 tile, cfg scrambled after start, start re-pulsed while busy
    cyc(1'b0, 1'b1);
    begin_tile(2, 3, 8'h11, 1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cfg_m = 8'd9; cfg_n = 8'd9;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    run_to_done(0, 100);
    chk("basic_issues", 32'(n_issued), 6);
    chk("basic_results", 32'(n_res), 6);
    chk("basic_first_valid", 32'(first_valid), 32'(t_start + 7));
    chk("basic_done_cycle", 32'(done_cycle), 32'(last_hs + 1));
    repeat (10) cyc(1'b0, 1'b1);
    chk("basic_done_once", 32'(n_done), 1);
    chk("busy_start_ignored", 32'(n_issued), 6);
    chk("basic_idle_busy", 32'(busy), 0);

    // Zero-size tile
    begin_tile(0, 5, 8'h22, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    chk("zero_done_cycle", 32'(done_cycle), 32'(t_start + 1));
    chk("zero_done_once", 32'(n_done), 1);
    chk("zero_no_issue", 32'(n_issued), 0);
    chk("zero_no_result", 32'(n_res), 0);

    // Backpressure 4x4
    begin_tile(4, 4, 8'h33, 1'b0, 1'b0);
    repeat (25) cyc(1'b0, 1'b0);
    chk("bp_issue_stall", 32'(n_issued), 8);
    chk("bp_valid_held", 32'(res_valid), 1);
    chk("bp_no_result", 32'(n_res), 0);
    run_to_done(0, 200);
    chk("bp_issues", 32'(n_issued), 16);
    chk("bp_results", 32'(n_res), 16);
    chk("bp_max_outstanding", 32'(max_out), 8);

    // Random ready 5x7
    repeat (3) cyc(1'b0, 1'b1);
    begin_tile(5, 7, 8'h44, 1'b0, 1'b1);
    run_to_done(1, 2000);
    chk("rand_issues", 32'(n_issued), 35);
    chk("rand_results", 32'(n_res), 35);
    chk("rand_max_outstanding", 32'(max_out <= 8), 1);

    // Reset three cycles after the first issue, then a 1x1 tile
    repeat (3) cyc(1'b0, 1'b1);
    begin_tile(3, 3, 8'h55, 1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("abort_first_issue", 32'(n_issued), 1);
    repeat (3) cyc(1'b0, 1'b1);
    rst = 1'b0;
    #1;
    chk_zero("abort");
    d0 = n_done;
    hold_pending = 1'b0;
    repeat (3) cyc(1'b0, 1'b1);
    chk("abort_no_done", 32'(n_done), 32'(d0));
    rst = 1'b1;
    cyc(1'b0, 1'b1);
    begin_tile(1, 1, 8'h66, 1'b1, 1'b1);
    run_to_done(0, 50);
    repeat (10) cyc(1'b0, 1'b1);
    chk("single_issues", 32'(n_issued), 1);
    chk("single_results", 32'(n_res), 1);
    chk("single_first_valid", 32'(first_valid), 32'(t_start + 7));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
